// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write-port arbiter and its round-robin
// picker: a constant-evaluable clog2, the IDLE/BURST state encoding and the
// default sizing constants.
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_BEATS  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    // Returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_rr_pick (rr_pick)
// Combinational round-robin priority pick: the winner is the first asserted
// request at or after ptr, wrapping modulo N.
//
// Ports:
//   req      in  N      request vector
//   ptr      in  IW     highest-priority index this round (must be < N)
//   onehot   out N      one-hot winner, zero when no request
//   idx      out IW     winner index, zero when no request
//   any_req  out 1      at least one request asserted
// ---------------------------------------------------------------------------
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [N-1:0]          onehot,
    output logic [clog2(N)-1:0]   idx,
    output logic                  any_req
);

    localparam int IW = clog2(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        // Rotate so that bit 0 of rot is request[ptr]; the first set bit of
        // rot is then the offset of the winner from ptr.
        dbl     = {req, req} >> ptr;
        rot     = dbl[N-1:0];
        any_req = 1'b0;
        off     = '0;
        for (int i = 0; i < N; i++) begin
            if (!any_req && rot[i]) begin
                any_req = 1'b1;
                off     = IW'(i);
            end
        end

        // ptr + off is below 2N, so a single conditional subtract wraps it.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx = sum[IW-1:0];

        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = any_req && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of a FIFO among NUM_REQ requesters. Grants are
// round-robin at burst granularity and a burst is never interrupted by another
// requester. A watchdog forces release after MAX_BEATS accepted beats.
//
// Ports:
//   wr_clk        in  1                   write-domain clock
//   wr_rst        in  1                   synchronous reset, active-high
//   req_valid     in  NUM_REQ             per-requester beat valid
//   req_last      in  NUM_REQ             per-requester last beat of burst
//   req_data      in  NUM_REQ*DATA_WIDTH  beat data, slice i = requester i
//   req_ready     out NUM_REQ             per-requester beat accepted
//   fifo_full     in  1                   registered FIFO full flag
//   fifo_wr_en    out 1                   FIFO write strobe
//   fifo_wr_data  out DATA_WIDTH          FIFO write data
//   grant         out NUM_REQ             one-hot owner, zero when idle
//   busy          out 1                   a grant is held
//   burst_err     out 1                   one-cycle pulse on watchdog release
//   err_id        out clog2(NUM_REQ)      owner of the last watchdog release
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          burst_err,
    output logic [clog2(NUM_REQ)-1:0]     err_id
);

    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_BEATS);

    arb_state_t          state;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       own_idx;
    logic [CW-1:0]       beat_cnt;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;

    logic                accept;
    logic                own_last;
    logic                cap_hit;
    logic [IW-1:0]       next_ptr;

    fifo_wr_arbiter_rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // Owner-side decode. grant is all-zero in IDLE, so masking with grant
    // also forces the data mux and ready vector to zero there.
    always_comb begin
        accept   = (state == ST_BURST) && !fifo_full && |(req_valid & grant);
        own_last = |(req_last & grant);
        cap_hit  = (beat_cnt == CW'(MAX_BEATS - 1));
        next_ptr = (own_idx == IW'(NUM_REQ - 1)) ? '0 : own_idx + IW'(1);

        fifo_wr_en = accept;
        req_ready  = ((state == ST_BURST) && !fifo_full) ? grant : '0;

        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            own_idx   <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
            err_id    <= '0;
        end else begin
            burst_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Arbitration cycle: no beat is accepted here.
                    if (pick_any) begin
                        state    <= ST_BURST;
                        grant    <= pick_onehot;
                        own_idx  <= pick_idx;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    // Stalled or invalid cycles leave everything untouched.
                    if (accept) begin
                        if (own_last || cap_hit) begin
                            state    <= ST_IDLE;
                            grant    <= '0;
                            busy     <= 1'b0;
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                            // A last on the MAX_BEATS-th beat is a clean end.
                            if (!own_last) begin
                                burst_err <= 1'b1;
                                err_id    <= own_idx;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BEATS=16).
// Requesters are driven from per-requester beat queues that only advance on a
// handshake. A behavioural model predicts every output each cycle; directed
// checkpoints pin grant order, write data order, timing and watchdog events.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 16;

    logic           wr_clk;
    logic           wr_rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic [N-1:0]   grant;
    logic           busy;
    logic           burst_err;
    logic [1:0]     err_id;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .MAX_BEATS  (MB)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant        (grant),
        .busy         (busy),
        .burst_err    (burst_err),
        .err_id       (err_id)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int r, input int s, input int b);
        return {8'(r), 8'(s), 16'(b)};
    endfunction

    // ---------------- stimulus queues ----------------
    logic [32:0] bq [N][$];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = bq[i][0][32];
                req_data[i*W +: W]  = bq[i][0][31:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[i*W +: W]  = '0;
            end
        end
    endtask

    task automatic load(input int r, input int s, input int n, input int last_at);
        for (int b = 1; b <= n; b++) bq[r].push_back({(b == last_at), mk(r, s, b)});
        apply();
    endtask

    // One clock: sample handshakes before the edge, advance queues after it.
    task automatic cycle();
        logic [N-1:0] hs;
        #1;
        hs = req_ready & req_valid;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && bq[i].size() > 0) void'(bq[i].pop_front());
        end
        apply();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_idle(input int max, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            cycle();
            n++;
            done = all_empty() && (busy === 1'b0);
        end
        chk(name, 64'(done), 64'd1);
    endtask

    // ---------------- behavioural model ----------------
    // m_own = -1 when nobody owns the port; m_cnt counts accepted beats.
    int          m_own = -1;
    int          m_cnt = 0;
    int          m_rr  = 0;
    bit          m_err = 1'b0;
    int          m_eid = 0;
    bit          m_ok  = 1'b0;
    int          nerr  = 0;
    int          glog[$];
    logic [31:0] wlog[$];

    always @(negedge wr_clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ew;
        logic [W-1:0] ed;
        bit           found;
        int           c;
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        ew = (m_own >= 0) && req_valid[m_own] && !fifo_full;
        ed = (m_own >= 0) ? req_data[m_own*W +: W] : '0;
        er = ((m_own >= 0) && !fifo_full) ? eg : '0;
        if (m_ok) begin
            chk("grant", 64'(grant), 64'(eg));
            chk("busy", 64'(busy), 64'(m_own >= 0));
            chk("fifo_wr_en", 64'(fifo_wr_en), 64'(ew));
            chk("fifo_wr_data", 64'(fifo_wr_data), 64'(ed));
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("burst_err", 64'(burst_err), 64'(m_err));
            chk("err_id", 64'(err_id), 64'(m_eid));
            if (ew) wlog.push_back(ed);
        end
        if (wr_rst) begin
            m_own = -1; m_cnt = 0; m_rr = 0; m_err = 1'b0; m_eid = 0; m_ok = 1'b1;
        end else if (m_ok) begin
            m_err = 1'b0;
            if (m_own < 0) begin
                found = 1'b0;
                for (int j = 0; j < N; j++) begin
                    c = (m_rr + j) % N;
                    if (!found && req_valid[c]) begin
                        found = 1'b1;
                        m_own = c;
                        m_cnt = 0;
                        glog.push_back(c);
                    end
                end
            end else if (ew) begin
                m_cnt++;
                if (req_last[m_own] || m_cnt == MB) begin
                    if (!req_last[m_own]) begin
                        m_err = 1'b1;
                        m_eid = m_own;
                        nerr++;
                    end
                    m_rr  = (m_own + 1) % N;
                    m_own = -1;
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int w0;
        int g0;
        int e0;
        wr_rst    = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < 3; i++) cycle();
        wr_rst = 1'b0;

        // Reset state
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_burst_err", 64'(burst_err), 64'd0);
        chk("rst_err_id", 64'(err_id), 64'd0);

        // Idle for 10 cycles
        w0 = wlog.size();
        for (int i = 0; i < 10; i++) cycle();
        chk("idle_writes", 64'(wlog.size() - w0), 64'd0);
        chk("idle_data", 64'(fifo_wr_data), 64'd0);

        // Four simultaneous 2-beat bursts: 12 cycles end to end
        w0 = wlog.size();
        g0 = glog.size();
        for (int r = 0; r < N; r++) load(r, 2, 2, 2);
        for (int i = 0; i < 11; i++) cycle();
        chk("rr4_writes_11", 64'(wlog.size() - w0), 64'd7);
        chk("rr4_busy_11", 64'(busy), 64'd1);
        cycle();
        chk("rr4_writes_12", 64'(wlog.size() - w0), 64'd8);
        chk("rr4_busy_12", 64'(busy), 64'd0);
        for (int r = 0; r < N; r++) begin
            chk("rr4_order", 64'(glog[g0 + r]), 64'(r));
            for (int b = 0; b < 2; b++) chk("rr4_data", 64'(wlog[w0 + 2*r + b]), 64'(mk(r, 2, b + 1)));
        end

        // Requester 2, 4 beats, full for 3 cycles on beats 2 and 4
        w0 = wlog.size();
        load(2, 3, 4, 4);
        for (int k = 1; k <= 11; k++) begin
            fifo_full = ((k >= 3 && k <= 5) || (k >= 8 && k <= 10));
            #1;
            if (k == 4)  chk("full_ready_lo", 64'(req_ready), 64'd0);
            if (k == 9)  chk("full_last_hold", 64'(fifo_wr_en), 64'd0);
            if (k == 6)  chk("full_ready_hi", 64'(req_ready), 64'b0100);
            if (k == 11) chk("full_busy_10", 64'(busy), 64'd1);
            cycle();
        end
        fifo_full = 1'b0;
        chk("full_writes", 64'(wlog.size() - w0), 64'd4);
        chk("full_released", 64'(busy), 64'd0);
        for (int b = 0; b < 4; b++) chk("full_data", 64'(wlog[w0 + b]), 64'(mk(2, 3, b + 1)));

        // Requester 1: 20 beats, watchdog fires at beat 16
        w0 = wlog.size();
        g0 = glog.size();
        e0 = nerr;
        load(1, 4, 20, 20);
        cycle();
        chk("wd_grant", 64'(grant), 64'b0010);
        load(2, 4, 1, 1);
        load(3, 4, 1, 1);
        for (int i = 0; i < 16; i++) cycle();
        chk("wd_writes", 64'(wlog.size() - w0), 64'd16);
        chk("wd_burst_err", 64'(burst_err), 64'd1);
        chk("wd_err_id", 64'(err_id), 64'd1);
        chk("wd_grant_drop", 64'(grant), 64'd0);
        cycle();
        chk("wd_pulse_end", 64'(burst_err), 64'd0);
        chk("wd_next_owner", 64'(grant), 64'b0100);
        run_until_idle(40, "wd_drain");
        chk("wd_order0", 64'(glog[g0]), 64'd1);
        chk("wd_order1", 64'(glog[g0 + 1]), 64'd2);
        chk("wd_order2", 64'(glog[g0 + 2]), 64'd3);
        chk("wd_order3", 64'(glog[g0 + 3]), 64'd1);
        chk("wd_err_count", 64'(nerr - e0), 64'd1);
        chk("wd_total_writes", 64'(wlog.size() - w0), 64'd22);

        // Requester 0: last exactly on beat 16 is a clean release
        w0 = wlog.size();
        e0 = nerr;
        load(0, 5, 16, 16);
        run_until_idle(40, "b16_drain");
        chk("b16_writes", 64'(wlog.size() - w0), 64'd16);
        chk("b16_no_err", 64'(nerr - e0), 64'd0);
        chk("b16_err_id_held", 64'(err_id), 64'd1);
        chk("b16_last_data", 64'(wlog[w0 + 15]), 64'(mk(0, 5, 16)));

        // Requester 3: reset on beat 3 of a 6-beat burst
        w0 = wlog.size();
        g0 = glog.size();
        load(3, 6, 6, 6);
        for (int i = 0; i < 3; i++) cycle();
        wr_rst = 1'b1;
        cycle();
        wr_rst = 1'b0;
        chk("mrst_grant", 64'(grant), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("mrst_err_id", 64'(err_id), 64'd0);
        chk("mrst_writes", 64'(wlog.size() - w0), 64'd3);
        bq[3].delete();
        load(1, 7, 1, 1);
        load(3, 7, 1, 1);
        cycle();
        chk("mrst_winner", 64'(grant), 64'b0010);
        run_until_idle(20, "mrst_drain");
        chk("mrst_order0", 64'(glog[g0]), 64'd3);
        chk("mrst_order1", 64'(glog[g0 + 1]), 64'd1);
        chk("mrst_order2", 64'(glog[g0 + 2]), 64'd3);
        chk("mrst_total_writes", 64'(wlog.size() - w0), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
